// File: rtl/enigma_pkg.sv
// rtl/enigma_pkg.sv - shared Enigma alphabet, rotor wirings, notches and mod-ALPHA helpers
package enigma_pkg;

    localparam int ALPHA     = 26;
    localparam int CW        = 5;
    localparam int NUM_TYPES = 8;
    localparam int TW        = 3;

    localparam logic [CW:0] ALPHA_X = (CW+1)'(ALPHA);

    typedef enum logic [TW-1:0] {
        ROT_I, ROT_II, ROT_III, ROT_IV, ROT_V, ROT_VI, ROT_VII, ROT_VIII
    } rotor_t;

    typedef logic [NUM_TYPES-1:0][ALPHA-1:0][CW-1:0] wiring_t;

    localparam logic [CW-1:0] NOTCH_I   = 5'd16;
    localparam logic [CW-1:0] NOTCH_II  = 5'd4;
    localparam logic [CW-1:0] NOTCH_III = 5'd21;
    localparam logic [CW-1:0] NOTCH_IV  = 5'd9;
    localparam logic [CW-1:0] NOTCH_V   = 5'd25;
    localparam logic [CW-1:0] NOTCH_Z   = 5'd25;
    localparam logic [CW-1:0] NOTCH_M   = 5'd12;

    // Historical wirings as letter strings; leftmost letter is the output for contact A.
    function automatic logic [8*ALPHA-1:0] wiring_str(input int t);
        logic [8*ALPHA-1:0] s;
        case (t)
            0:       s = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
            1:       s = "AJDKSIRUXBLHWTMCQGZNPYFVOE";
            2:       s = "BDFHJLCPRTXVZNYEIWGAKMOUSQ";
            3:       s = "ESOVPZJAYQUIRHXLNFTGKDCMWB";
            4:       s = "VZBRGITYUPSDNHLXAWMJQOFECK";
            5:       s = "JPGVOUMFYQBENHZRDKASXLICTW";
            6:       s = "NZJHGRCXMYSWBOUFAIVLPEKQDT";
            7:       s = "FKQHTLXOCBJSPDZRAMEWNIUYGV";
            default: s = "ABCDEFGHIJKLMNOPQRSTUVWXYZ";
        endcase
        return s;
    endfunction

    function automatic wiring_t build_fwd();
        wiring_t w;
        logic [8*ALPHA-1:0] s;
        logic [7:0] ch;
        w = '0;
        for (int t = 0; t < NUM_TYPES; t++) begin
            s = wiring_str(t);
            for (int i = 0; i < ALPHA; i++) begin
                ch = s[8*(ALPHA-1-i) +: 8];
                w[t][i] = CW'(ch - 8'h41);
            end
        end
        return w;
    endfunction

    function automatic wiring_t build_inv(input wiring_t f);
        wiring_t w;
        w = '0;
        for (int t = 0; t < NUM_TYPES; t++)
            for (int i = 0; i < ALPHA; i++)
                w[t][f[t][i]] = CW'(i);
        return w;
    endfunction

    localparam wiring_t WIRE_FWD = build_fwd();
    localparam wiring_t WIRE_INV = build_inv(WIRE_FWD);

    // Inputs stay below 3*ALPHA, so two conditional subtractions always reach range.
    function automatic logic [CW-1:0] mod_fold(input logic [CW:0] x);
        logic [CW:0] r;
        r = x;
        if (r >= ALPHA_X) r = r - ALPHA_X;
        if (r >= ALPHA_X) r = r - ALPHA_X;
        return r[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] mod_add(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return mod_fold({1'b0, a} + {1'b0, b});
    endfunction

    function automatic logic [CW-1:0] mod_sub(input logic [CW-1:0] a, input logic [CW-1:0] b);
        return mod_fold({1'b0, a} + ALPHA_X - {1'b0, b});
    endfunction

    function automatic logic is_notch(input logic [TW-1:0] t, input logic [CW-1:0] p);
        case (rotor_t'(t))
            ROT_I:   return p == NOTCH_I;
            ROT_II:  return p == NOTCH_II;
            ROT_III: return p == NOTCH_III;
            ROT_IV:  return p == NOTCH_IV;
            ROT_V:   return p == NOTCH_V;
            default: return (p == NOTCH_Z) || (p == NOTCH_M);
        endcase
    endfunction

endpackage

// File: rtl/rotor_wiring_rom.sv
// rtl/rotor_wiring_rom.sv - combinational rotor wiring lookup, forward or inverse
module rotor_wiring_rom
    import enigma_pkg::*;
(
    input  logic [TW-1:0] rtype,
    input  logic          dir,
    input  logic [CW-1:0] code,
    output logic [CW-1:0] wired
);

    // Unknown types and out-of-alphabet contacts pass straight through.
    always_comb begin
        wired = code;
        if ((int'(rtype) < NUM_TYPES) && (int'(code) < ALPHA))
            wired = dir ? WIRE_INV[rtype][code] : WIRE_FWD[rtype][code];
    end

endmodule

// File: rtl/rotor_stage.sv
// rtl/rotor_stage.sv - clocked Enigma rotor stage with stepping, ring offset and one-deep handshake
module rotor_stage #(
    parameter int ALPHA     = enigma_pkg::ALPHA,
    parameter int CW        = enigma_pkg::CW,
    parameter int NUM_TYPES = enigma_pkg::NUM_TYPES,
    parameter int TW        = enigma_pkg::TW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [TW-1:0] cfg_type,
    input  logic [CW-1:0] cfg_ring,
    input  logic [CW-1:0] cfg_pos,
    input  logic          step,
    output logic [CW-1:0] pos,
    output logic          at_notch,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] in_code,
    input  logic          in_dir,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_code,
    output logic          out_dir,
    output logic          out_err
);
    import enigma_pkg::*;

    logic [CW-1:0] ring_q;
    logic [TW-1:0] type_q;
    logic [CW-1:0] off;
    logic [CW-1:0] contact;
    logic [CW-1:0] wired;
    logic [CW-1:0] subst;
    logic          code_err;
    logic          accept;
    logic          cfg_load;

    assign cfg_ready = !out_valid;
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign cfg_load  = cfg_valid && cfg_ready;

    assign at_notch  = (int'(type_q) < NUM_TYPES) && is_notch(type_q, pos);

    // The wiring is fixed to the housing; position and ring rotate the contacts against it.
    assign off      = mod_sub(pos, ring_q);
    assign contact  = mod_add(in_code, off);
    assign subst    = mod_sub(wired, off);
    assign code_err = int'(in_code) >= ALPHA;

    rotor_wiring_rom u_rom (
        .rtype (type_q),
        .dir   (in_dir),
        .code  (contact),
        .wired (wired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pos       <= '0;
            ring_q    <= '0;
            type_q    <= '0;
            out_valid <= 1'b0;
            out_code  <= '0;
            out_dir   <= 1'b0;
            out_err   <= 1'b0;
        end else begin
            if (cfg_load) begin
                type_q <= cfg_type;
                ring_q <= cfg_ring;
                pos    <= cfg_pos;
            end else if (step) begin
                pos <= (pos == CW'(ALPHA - 1)) ? '0 : pos + 1'b1;
            end

            if (accept) begin
                out_valid <= 1'b1;
                out_code  <= code_err ? in_code : subst;
                out_dir   <= in_dir;
                out_err   <= code_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rotor_stage.sv
// tb/tb_rotor_stage.sv - randomized self-checking bench for rotor_stage against a letter-level model
module tb_rotor_stage;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [2:0] cfg_type = '0;
    logic [4:0] cfg_ring = '0;
    logic [4:0] cfg_pos = '0;
    logic       step = 1'b0;
    logic [4:0] pos;
    logic       at_notch;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_code = '0;
    logic       in_dir = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [4:0] out_code;
    logic       out_dir;
    logic       out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotor_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_type  (cfg_type),
        .cfg_ring  (cfg_ring),
        .cfg_pos   (cfg_pos),
        .step      (step),
        .pos       (pos),
        .at_notch  (at_notch),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_dir    (in_dir),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_code  (out_code),
        .out_dir   (out_dir),
        .out_err   (out_err)
    );

    string rotor_s [8] = '{
        "EKMFLGDQVZNTOWYHXUSPAIBRCJ", "AJDKSIRUXBLHWTMCQGZNPYFVOE",
        "BDFHJLCPRTXVZNYEIWGAKMOUSQ", "ESOVPZJAYQUIRHXLNFTGKDCMWB",
        "VZBRGITYUPSDNHLXAWMJQOFECK", "JPGVOUMFYQBENHZRDKASXLICTW",
        "NZJHGRCXMYSWBOUFAIVLPEKQDT", "FKQHTLXOCBJSPDZRAMEWNIUYGV"};
    string notch_s [8] = '{"Q", "E", "V", "J", "Z", "ZM", "ZM", "ZM"};

    function automatic int m_wire(int t, int d, int c);
        string s;
        s = rotor_s[t];
        if (d == 0) return int'(s[c]) - 65;
        for (int i = 0; i < 26; i++)
            if (int'(s[i]) - 65 == c) return i;
        return c;
    endfunction

    function automatic int m_subst(int t, int ring, int p, int code, int d);
        int off;
        if (code >= 26) return code;
        off = ((p - ring) % 26 + 26) % 26;
        return ((m_wire(t, d, (code + off) % 26) - off) % 26 + 26) % 26;
    endfunction

    function automatic int m_notch(int t, int p);
        string s;
        s = notch_s[t];
        for (int i = 0; i < s.len(); i++)
            if (int'(s[i]) - 65 == p) return 1;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: what the stage must hold after each edge.
    int m_pos, m_ring, m_type, m_code, m_dir, m_err;
    bit m_valid;

    always @(posedge clk or negedge reset_n) begin
        bit cfg_rdy, in_rdy;
        int r;
        if (!reset_n) begin
            m_pos = 0; m_ring = 0; m_type = 0;
            m_valid = 0; m_code = 0; m_dir = 0; m_err = 0;
        end else begin
            cfg_rdy = !m_valid;
            in_rdy  = !m_valid || out_ready;
            r = m_subst(m_type, m_ring, m_pos, int'(in_code), int'(in_dir));
            if (in_valid && in_rdy) begin
                m_valid = 1; m_code = r; m_dir = int'(in_dir); m_err = (in_code >= 26) ? 1 : 0;
            end else if (out_ready) begin
                m_valid = 0;
            end
            if (cfg_valid && cfg_rdy) begin
                m_type = int'(cfg_type); m_ring = int'(cfg_ring); m_pos = int'(cfg_pos);
            end else if (step) begin
                m_pos = (m_pos + 1) % 26;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("pos", int'(pos), m_pos);
            chk("at_notch", int'(at_notch), m_notch(m_type, m_pos));
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("cfg_ready", int'(cfg_ready), int'(!m_valid));
            chk("in_ready", int'(in_ready), int'(!m_valid || out_ready));
            if (m_valid) begin
                chk("out_code", int'(out_code), m_code);
                chk("out_dir", int'(out_dir), m_dir);
                chk("out_err", int'(out_err), m_err);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int t, input int r, input int p);
        cfg_valid = 1'b1; cfg_type = 3'(t); cfg_ring = 5'(r); cfg_pos = 5'(p);
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic send(input int code, input int d, input int exp, input int exp_err);
        in_valid = 1'b1; in_code = 5'(code); in_dir = d[0];
        tick();
        in_valid = 1'b0;
        chk("send_valid", int'(out_valid), 1);
        chk("send_code", int'(out_code), exp);
        chk("send_err", int'(out_err), exp_err);
        tick();
    endtask

    initial begin
        repeat (2) tick();
        chk("rst_pos", int'(pos), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_code", int'(out_code), 0);
        chk("rst_out_dir", int'(out_dir), 0);
        chk("rst_out_err", int'(out_err), 0);
        reset_n = 1'b1;
        out_ready = 1'b1;

        chk("model_fwd_a", m_subst(0, 0, 0, 0, 0), 4);
        chk("model_rev_a", m_subst(0, 0, 0, 0, 1), 20);
        chk("model_pos1", m_subst(0, 0, 1, 0, 0), 9);
        chk("model_ring1", m_subst(0, 1, 0, 0, 0), 10);

        load(0, 0, 0);
        send(0, 0, 4, 0);
        send(0, 1, 20, 0);
        send(20, 0, 0, 0);
        load(0, 0, 1);
        send(0, 0, 9, 0);
        load(0, 1, 0);
        send(0, 0, 10, 0);

        load(0, 0, 15);
        step = 1'b1; tick(); step = 1'b0;
        chk("step_pos16", int'(pos), 16);
        chk("notch_q", int'(at_notch), 1);
        step = 1'b1; tick(); step = 1'b0;
        chk("step_pos17", int'(pos), 17);
        chk("notch_off", int'(at_notch), 0);
        load(0, 0, 25);
        step = 1'b1; tick(); step = 1'b0;
        chk("wrap_pos", int'(pos), 0);

        load(5, 0, 0);
        step = 1'b1;
        for (int p = 1; p <= 26; p++) begin
            tick();
            chk("notch_vi", int'(at_notch), ((p % 26) == 12 || (p % 26) == 25) ? 1 : 0);
        end
        step = 1'b0;

        load(0, 0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 5'd0; in_dir = 1'b0;
        tick();
        in_code = 5'd1;
        cfg_valid = 1'b1; cfg_type = 3'd0; cfg_ring = 5'd0; cfg_pos = 5'd7;
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_code", int'(out_code), 4);
            chk("stall_in_ready", int'(in_ready), 0);
            chk("stall_cfg_hold", int'(pos), 0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("drain_code1", int'(out_code), 10);
        in_code = 5'd2;
        tick();
        chk("drain_code2", int'(out_code), 12);
        in_valid = 1'b0;
        tick();
        chk("drain_empty", int'(out_valid), 0);
        chk("cfg_still_held", int'(pos), 0);
        tick();
        chk("cfg_after_stall", int'(pos), 7);
        cfg_valid = 1'b0;
        tick();

        send(27, 0, 27, 1);
        cfg_valid = 1'b1; cfg_type = 3'd0; cfg_ring = 5'd0; cfg_pos = 5'd9; step = 1'b1;
        tick();
        cfg_valid = 1'b0; step = 1'b0;
        chk("cfg_beats_step", int'(pos), 9);

        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_code   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
            in_dir    = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step      = ($urandom_range(0, 4) == 0);
            cfg_valid = ($urandom_range(0, 19) == 0);
            cfg_type  = 3'($urandom_range(0, 7));
            cfg_ring  = 5'($urandom_range(0, 25));
            cfg_pos   = 5'($urandom_range(0, 25));
            tick();
        end
        in_valid = 1'b0; cfg_valid = 1'b0; step = 1'b0;

        load(0, 0, 5);
        out_ready = 1'b0;
        in_valid = 1'b1; in_code = 5'd3;
        tick();
        in_valid = 1'b0;
        chk("pre_reset_valid", int'(out_valid), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", int'(out_valid), 0);
        chk("async_rst_pos", int'(pos), 0);
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rotor_stage.md
Name: rotor_stage

Overview:
- Single clocked Enigma rotor stage with a position register, ring setting and notch detection.
- Implements both the forward (entry->reflector) and reverse (reflector->entry) substitution through a one-deep valid/ready pipeline.
- Cascaded by the machine top level: the stage's at_notch drives the step/double-step logic of the neighbouring stage.
- Successor to the purely combinational wiring lookup; adds stepping, ring offset, handshake and parametrised alphabet/type count.

Parameters:
- ALPHA, 26, alphabet size; legal codes 0..ALPHA-1.
- CW, 5, code width; must satisfy 2^CW >= ALPHA.
- NUM_TYPES, 8, number of rotor wirings (types 0..7 = I..VIII).
- TW, 3, rotor type select width.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- cfg_valid  in  1  load request for type/ring/position.
- cfg_ready  out  1  high when the pipeline is empty (!out_valid).
- cfg_type  in  TW  rotor type.
- cfg_ring  in  CW  ring setting (Ringstellung).
- cfg_pos  in  CW  start position (Grundstellung).
- step  in  1  advance position by one this cycle.
- pos  out  CW  current position.
- at_notch  out  1  current position is a turnover notch of the current type.
- in_valid  in  1  input handshake valid.
- in_ready  out  1  input handshake ready.
- in_code  in  CW  input letter code.
- in_dir  in  1  0 = forward, 1 = reverse.
- out_valid  out  1  output handshake valid.
- out_ready  in  1  output handshake ready.
- out_code  out  CW  substituted letter code.
- out_dir  out  1  echo of in_dir.
- out_err  out  1  input code was >= ALPHA.

Behaviour:
- Reset (async, reset_n low): pos=0, ring=0, type=0, out_valid=0, out_code=0, out_dir=0, out_err=0. Reset mid-transfer drops the in-flight beat.
- Config:
  - Load occurs on cfg_valid && cfg_ready; type, ring and pos are loaded at the clock edge.
  - If cfg and step coincide, cfg wins and step is ignored.
  - If cfg_valid is high and cfg_ready is low, nothing is loaded. The requester holds cfg_valid.
- Stepping:
  - On step (no accepted cfg): pos <= (pos+1 == ALPHA) ? 0 : pos+1, so 25 wraps to 0.
  - Step is independent of the data handshake.
- Notch:
  - at_notch is combinational from pos and type.
  - Type 0 (I)=16 (Q); 1 (II)=4 (E); 2 (III)=21 (V); 3 (IV)=9 (J); 4 (V)=25 (Z).
  - Types 5..7 (VI..VIII) have two notches, 25 and 12 (Z, M).
- Data path, accept on in_valid && in_ready:
  - off = pos - ring mod ALPHA.
  - c = (in_code + off) mod ALPHA.
  - w = wiring[type][dir][c].
  - out_code <= (w - off) mod ALPHA.
  - All mod arithmetic uses CW+1 bits: add ALPHA, then conditionally subtract ALPHA once or twice. No divider.
  - Substitution uses the registered pos before any same-cycle step.
- Latency and handshake:
  - Latency is 1 cycle, accept to out_valid.
  - in_ready = !out_valid || out_ready, giving full throughput with no bubbles while out_ready is held high.
  - out_valid clears on out_ready when there is no new accept. out_code, out_dir and out_err are held stable while out_valid && !out_ready.
- Error: in_code >= ALPHA gives out_code = in_code unchanged and out_err = 1, with no table access.
- Unused types (>= NUM_TYPES) decode as identity wiring, and at_notch = 0.

Decomposition:
- Package enigma_pkg holds:
  - ALPHA and CW.
  - Rotor type enum ROT_I..ROT_VIII.
  - Forward and inverse wiring constant arrays [NUM_TYPES][ALPHA].
  - Notch position constants.
  - A mod-ALPHA add/sub function.
- Sub-module rotor_wiring_rom is combinational. Inputs: type, dir, contact code. Output: wired code. It is shared with the future reflector/plugboard blocks.

Test Plan:
- Forward identity offset: cfg type=0, ring=0, pos=0; in_code=0, dir=0 -> out_code=4 (E), out_err=0, out_valid one cycle after accept.
- Reverse path: same cfg, in_code=0, dir=1 -> out_code=20 (U). Forward of 20 returns 0, confirming inverse tables.
- Position and ring:
  - type 0, pos=1, ring=0, in_code=0 fwd -> out_code=9 (J).
  - type 0, pos=0, ring=1, in_code=0 fwd -> out_code=10 (K).
- Stepping, wrap and notch:
  - type 0, pos=15; step one cycle -> pos=16, at_notch=1; step -> pos=17, at_notch=0.
  - load pos=25; step -> pos=0.
  - type 5: at_notch=1 at pos 12 and 25 only.
- Backpressure:
  - Stream codes 0,1,2 with out_ready=0 for 3 cycles: out_code held at the first result, in_ready=0.
  - Release out_ready: remaining results appear in order, one per cycle.
  - cfg_valid during the stall is not accepted until out_valid falls.
- Edge cases:
  - in_code=27 -> out_code=27, out_err=1.
  - cfg_valid and step in the same cycle -> pos=cfg_pos.
  - Assert reset_n low with out_valid=1 -> out_valid=0 immediately (async), pos=0.
